// File: rtl/device_event_queue_if.sv
// device_event_queue_if
//   Request/event bundle for device_event_queue.
//   Request side : a_valid/a_id/a_on, b_valid/b_id/b_on (driven by the feeders),
//                  req_ready (shared back-pressure from the queue).
//   Event side   : change/on_off (one transition per cycle towards the counter),
//                  active_map (per-device active bitmap), dropped ({B, A} redundant pulse).
//   master = feeder / monitor side, slave = the queue itself.
interface device_event_queue_if #(
  parameter int ID_W = 4
);
  localparam int N_DEV = 2 ** ID_W;

  logic             a_valid;
  logic [ID_W-1:0]  a_id;
  logic             a_on;
  logic             b_valid;
  logic [ID_W-1:0]  b_id;
  logic             b_on;
  logic             req_ready;
  logic             change;
  logic             on_off;
  logic [N_DEV-1:0] active_map;
  logic [1:0]       dropped;

  modport master (
    output a_valid, a_id, a_on, b_valid, b_id, b_on,
    input  req_ready, change, on_off, active_map, dropped
  );

  modport slave (
    input  a_valid, a_id, a_on, b_valid, b_id, b_on,
    output req_ready, change, on_off, active_map, dropped
  );
endinterface

// File: rtl/device_event_queue.sv
// device_event_queue
//   Filters join/leave requests from two device channels against a per-device
//   active bitmap, queues only real transitions in a small FIFO and emits at most
//   one change pulse per clock (on_off = direction) for the active-device counter.
//   Ports:
//     clk  - system clock, all logic on posedge
//     rst  - synchronous active-high reset; discards queued events and clears the map
//     bus  - device_event_queue_if.slave (request channels A/B, req_ready,
//            change/on_off, active_map, dropped)
module device_event_queue #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  device_event_queue_if.slave bus
);
  localparam int N_DEV = 2 ** ID_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Two free slots are needed because both channels may push in one cycle.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [N_DEV-1:0] active_map;
  logic             change;
  logic             on_off;
  logic [1:0]       dropped;

  logic             ready;
  logic             acc_a;
  logic             acc_b;
  logic             red_a;
  logic             red_b;
  logic             push_a;
  logic             push_b;
  logic             pop;
  logic [N_DEV-1:0] map_after_a;
  logic [N_DEV-1:0] map_next;
  logic [PTR_W-1:0] wr_ptr_b;
  logic [CNT_W-1:0] count_next;

  assign ready = !rst && (count <= READY_MAX);

  // Filtering runs A first; B is judged against the map as A leaves it, so
  // A join + B join on the same id yields a single event and drops B.
  always_comb begin
    acc_a       = bus.a_valid && ready;
    red_a       = (bus.a_on == active_map[bus.a_id]);
    push_a      = acc_a && !red_a;
    map_after_a = active_map;
    if (push_a) begin
      map_after_a[bus.a_id] = bus.a_on;
    end
    acc_b    = bus.b_valid && ready;
    red_b    = (bus.b_on == map_after_a[bus.b_id]);
    push_b   = acc_b && !red_b;
    map_next = map_after_a;
    if (push_b) begin
      map_next[bus.b_id] = bus.b_on;
    end
    pop        = (count != '0);
    wr_ptr_b   = push_a ? wr_ptr + PTR_W'(1) : wr_ptr;
    count_next = count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  // With at most DEPTH-2 entries held before a push, the write slots never alias
  // the head being popped in the same cycle.
  always_ff @(posedge clk) begin
    if (push_a) begin
      fifo_mem[wr_ptr] <= bus.a_on;
    end
    if (push_b) begin
      fifo_mem[wr_ptr_b] <= bus.b_on;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      active_map <= '0;
      change     <= 1'b0;
      on_off     <= 1'b0;
      dropped    <= 2'b00;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count      <= count_next;
      active_map <= map_next;
      change     <= pop;
      on_off     <= pop && fifo_mem[rd_ptr];
      dropped    <= {acc_b && red_b, acc_a && red_a};
    end
  end

  assign bus.req_ready  = ready;
  assign bus.change     = change;
  assign bus.on_off     = on_off;
  assign bus.active_map = active_map;
  assign bus.dropped    = dropped;
endmodule

// File: tb/tb_device_event_queue.sv
// tb_device_event_queue
//   Self-checking bench for device_event_queue. A cycle model (bitmap plus a
//   queue of expected on_off values) is advanced alongside the DUT; expected
//   events are pushed at acceptance and popped when a change pulse is due.
module tb_device_event_queue;
  localparam int ID_W  = 4;
  localparam int DEPTH = 8;
  localparam int N_DEV = 2 ** ID_W;

  logic clk;
  logic rst;

  device_event_queue_if #(.ID_W(ID_W)) bus ();

  device_event_queue #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;
  int mon_count;

  logic [N_DEV-1:0] m_map;
  logic             m_fifo[$];
  logic             last_change;
  logic             last_on_off;
  logic             last_ready_exp;

  task automatic set_req(input logic av, input logic [ID_W-1:0] aid, input logic aon,
                         input logic bv, input logic [ID_W-1:0] bid, input logic bon);
    bus.a_valid = av;
    bus.a_id    = aid;
    bus.a_on    = aon;
    bus.b_valid = bv;
    bus.b_id    = bid;
    bus.b_on    = bon;
  endtask

  // One clock: predict acceptance from the model, cross the edge, compare everything.
  task automatic step();
    logic       exp_ready;
    logic       exp_change;
    logic       exp_on;
    logic [1:0] exp_drop;
    logic       push_q[$];
    #1;
    exp_ready = !rst && (m_fifo.size() <= DEPTH - 2);
    last_ready_exp = exp_ready;
    tests++;
    if (bus.req_ready !== exp_ready) begin
      failed++;
      $display("[TB] FAIL req_ready: got %b expected %b", bus.req_ready, exp_ready);
    end
    exp_change = !rst && (m_fifo.size() != 0);
    exp_drop   = 2'b00;
    push_q     = {};
    if (exp_ready && bus.a_valid) begin
      if (bus.a_on == m_map[bus.a_id]) exp_drop[0] = 1'b1;
      else begin
        m_map[bus.a_id] = bus.a_on;
        push_q.push_back(bus.a_on);
      end
    end
    if (exp_ready && bus.b_valid) begin
      if (bus.b_on == m_map[bus.b_id]) exp_drop[1] = 1'b1;
      else begin
        m_map[bus.b_id] = bus.b_on;
        push_q.push_back(bus.b_on);
      end
    end
    @(posedge clk);
    #1;
    exp_on = 1'b0;
    if (rst) begin
      m_fifo.delete();
      m_map = '0;
    end else if (exp_change) begin
      exp_on = m_fifo.pop_front();
    end
    foreach (push_q[i]) m_fifo.push_back(push_q[i]);
    tests++;
    if (bus.change !== exp_change || bus.on_off !== exp_on) begin
      failed++;
      $display("[TB] FAIL event: got change=%b on_off=%b expected change=%b on_off=%b",
               bus.change, bus.on_off, exp_change, exp_on);
    end
    tests++;
    if (bus.active_map !== m_map) begin
      failed++;
      $display("[TB] FAIL active_map: got %h expected %h", bus.active_map, m_map);
    end
    tests++;
    if (bus.dropped !== exp_drop) begin
      failed++;
      $display("[TB] FAIL dropped: got %b expected %b", bus.dropped, exp_drop);
    end
    if (bus.change === 1'b1) mon_count += (bus.on_off === 1'b1) ? 1 : -1;
    last_change = bus.change;
    last_on_off = bus.on_off;
  endtask

  task automatic idle(input int n);
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    tests++;
    if (bus.req_ready !== 1'b0 || bus.change !== 1'b0 || bus.active_map !== '0) begin
      failed++;
      $display("[TB] FAIL reset_state: got ready=%b change=%b map=%h expected 0 0 0",
               bus.req_ready, bus.change, bus.active_map);
    end
    rst = 1'b0;
    mon_count = 0;
    idle(1);
  endtask

  task automatic test_single_join();
    set_req(1'b1, 4'd3, 1'b1, 1'b0, '0, 1'b0);
    step();
    tests++;
    if (last_change !== 1'b0) begin
      failed++;
      $display("[TB] FAIL join_latency_early: got change=%b expected 0", last_change);
    end
    idle(1);
    tests++;
    if (last_change !== 1'b1 || last_on_off !== 1'b1) begin
      failed++;
      $display("[TB] FAIL join_pulse: got change=%b on_off=%b expected 1 1", last_change, last_on_off);
    end
    tests++;
    if (bus.active_map !== 16'h0008) begin
      failed++;
      $display("[TB] FAIL join_map: got %h expected 0008", bus.active_map);
    end
    idle(2);
  endtask

  task automatic test_redundant_join();
    set_req(1'b1, 4'd3, 1'b1, 1'b0, '0, 1'b0);
    step();
    tests++;
    if (bus.dropped !== 2'b01) begin
      failed++;
      $display("[TB] FAIL redundant_drop: got %b expected 01", bus.dropped);
    end
    idle(1);
    tests++;
    if (bus.dropped !== 2'b00 || last_change !== 1'b0 || bus.active_map !== 16'h0008) begin
      failed++;
      $display("[TB] FAIL redundant_after: got dropped=%b change=%b map=%h expected 00 0 0008",
               bus.dropped, last_change, bus.active_map);
    end
    idle(2);
  endtask

  task automatic test_same_cycle();
    logic [1:0] seq;
    set_req(1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0);
    step();
    idle(1);
    seq[1] = last_change ? last_on_off : 1'bx;
    idle(1);
    seq[0] = last_change ? last_on_off : 1'bx;
    tests++;
    if (seq !== 2'b10 || bus.active_map[5] !== 1'b0) begin
      failed++;
      $display("[TB] FAIL join_leave_pair: got pulses=%b bit5=%b expected 10 0", seq, bus.active_map[5]);
    end
    idle(2);
    set_req(1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1);
    step();
    tests++;
    if (bus.dropped !== 2'b10) begin
      failed++;
      $display("[TB] FAIL double_join_drop: got %b expected 10", bus.dropped);
    end
    idle(1);
    seq[1] = last_change;
    idle(1);
    seq[0] = last_change;
    tests++;
    if (seq !== 2'b10 || bus.active_map[5] !== 1'b1) begin
      failed++;
      $display("[TB] FAIL double_join_pulses: got changes=%b bit5=%b expected 10 1", seq, bus.active_map[5]);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int next_id;
    int pulses;
    int run;
    int max_run;
    int ups;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    next_id = 0;
    pulses  = 0;
    run     = 0;
    max_run = 0;
    ups     = 0;
    for (int c = 0; c < 21; c++) begin
      if (c < 7) set_req(1'b1, ID_W'(next_id), 1'b1, 1'b1, ID_W'(next_id + 1), 1'b1);
      else       set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      step();
      if (c < 7 && last_ready_exp) next_id += 2;
      if (last_change === 1'b1) begin
        pulses++;
        run++;
        if (last_on_off === 1'b1) ups++;
        if (run > max_run) max_run = run;
      end else run = 0;
    end
    tests++;
    if (pulses != 12 || max_run != 12 || ups != 12) begin
      failed++;
      $display("[TB] FAIL back_to_back: got pulses=%0d run=%0d ups=%0d expected 12 12 12",
               pulses, max_run, ups);
    end
    tests++;
    if (bus.active_map !== 16'h0FFF) begin
      failed++;
      $display("[TB] FAIL back_to_back_map: got %h expected 0fff", bus.active_map);
    end
  endtask

  task automatic test_reset_mid_operation();
    int pulses;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_req(1'b1, ID_W'(2 * c), 1'b1, 1'b1, ID_W'(2 * c + 1), 1'b1);
      step();
    end
    tests++;
    if (m_fifo.size() != 5) begin
      failed++;
      $display("[TB] FAIL mid_reset_setup: got queued=%0d expected 5", m_fifo.size());
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    tests++;
    if (last_change !== 1'b0 || bus.active_map !== '0) begin
      failed++;
      $display("[TB] FAIL mid_reset: got change=%b map=%h expected 0 0000", last_change, bus.active_map);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      idle(1);
      if (last_change === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      failed++;
      $display("[TB] FAIL mid_reset_flush: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    mon_count = 0;
    for (int c = 0; c < 2000; c++) begin
      set_req(($urandom_range(0, 9) < 6), ID_W'($urandom_range(0, N_DEV - 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 6), ID_W'($urandom_range(0, N_DEV - 1)), 1'($urandom_range(0, 1)));
      step();
    end
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 3 * DEPTH && m_fifo.size() != 0; c++) step();
    idle(1);
    tests++;
    if (m_fifo.size() != 0) begin
      failed++;
      $display("[TB] FAIL random_drain: got %0d queued expected 0", m_fifo.size());
    end
    tests++;
    if (mon_count != $countones(m_map)) begin
      failed++;
      $display("[TB] FAIL monitor_count: got %0d expected %0d", mon_count, $countones(m_map));
    end
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    mon_count = 0;
    m_map     = '0;
    rst       = 1'b1;
    set_req(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    test_reset();
    test_single_join();
    test_redundant_join();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_operation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
